// File: rtl/if_fetch.sv
// Instruction fetch: owns the PC, issues ROM word reads, and buffers returns in a 2-entry queue.
// Latency: request at T is visible at the output from T+2; a jump target is valid at T+2.
// Backpressure: hold stops consumption, and issue is throttled so queue plus in-flight never exceeds 2.
module if_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] INST_NOP = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        hold_flag_i,
   input  logic        jump_flag_i,
   input  logic [31:0] jump_addr_i,
   output logic        rom_req_o,
   output logic [31:0] rom_addr_o,
   input  logic [31:0] rom_data_i,
   output logic [31:0] inst_addr_o,
   output logic [31:0] inst_o,
   output logic        inst_valid_o
);

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] inst;
   } fq_entry_t;

   logic [31:0] pc;
   logic        if_valid;
   logic [31:0] if_addr;
   fq_entry_t   fq [2];
   logic [1:0]  count;
   logic        wr_ptr;
   logic        rd_ptr;

   logic        consume;
   logic        push;
   logic [2:0]  occ;
   logic [31:0] req_addr;
   fq_entry_t   head;
   logic        unused_jump_lsbs;

   assign unused_jump_lsbs = ^jump_addr_i[1:0];

   assign consume  = !hold_flag_i && (count != 2'd0) && !jump_flag_i;
   assign push     = if_valid && !jump_flag_i;
   // Occupancy after this cycle's pop: queued entries plus the response still on its way back.
   assign occ      = {1'b0, count} + {2'b00, if_valid} - {2'b00, consume};
   assign req_addr = jump_flag_i ? {jump_addr_i[31:2], 2'b00} : pc;

   assign rom_req_o  = rst && (jump_flag_i || (occ < 3'd2));
   assign rom_addr_o = req_addr;

   assign head         = fq[rd_ptr];
   assign inst_valid_o = rst && (count != 2'd0) && !jump_flag_i;
   assign inst_o       = inst_valid_o ? head.inst : INST_NOP;
   assign inst_addr_o  = (rst && (count != 2'd0)) ? head.addr : 32'd0;

   always_ff @(posedge clk) begin
      if (!rst) begin
         pc       <= RESET_PC;
         if_valid <= 1'b0;
         if_addr  <= 32'd0;
      end else if (rom_req_o) begin
         pc       <= req_addr + 32'd4;
         if_valid <= 1'b1;
         if_addr  <= req_addr;
      end else begin
         if_valid <= 1'b0;
      end
   end

   // A jump flushes the queue and drops whatever the ROM returns this cycle.
   always_ff @(posedge clk) begin
      if (!rst) begin
         count  <= 2'd0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
      end else if (jump_flag_i) begin
         count  <= 2'd0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
      end else begin
         if (push)
            wr_ptr <= ~wr_ptr;
         if (consume)
            rd_ptr <= ~rd_ptr;
         count <= count + {1'b0, push} - {1'b0, consume};
      end
   end

   always_ff @(posedge clk) begin
      if (rst && push)
         fq[wr_ptr] <= '{addr: if_addr, inst: rom_data_i};
   end

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch with a one-cycle-latency ROM model.
module tb_if_fetch;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        hold_flag_i = 1'b0;
   logic        jump_flag_i = 1'b0;
   logic [31:0] jump_addr_i = 32'd0;
   logic        rom_req_o;
   logic [31:0] rom_addr_o;
   logic [31:0] rom_data_i = 32'd0;
   logic [31:0] inst_addr_o;
   logic [31:0] inst_o;
   logic        inst_valid_o;

   int tests = 0;
   int fails = 0;

   if_fetch #(.RESET_PC(32'h0000_0000), .INST_NOP(NOP)) dut (
      .clk          (clk),
      .rst          (rst),
      .hold_flag_i  (hold_flag_i),
      .jump_flag_i  (jump_flag_i),
      .jump_addr_i  (jump_addr_i),
      .rom_req_o    (rom_req_o),
      .rom_addr_o   (rom_addr_o),
      .rom_data_i   (rom_data_i),
      .inst_addr_o  (inst_addr_o),
      .inst_o       (inst_o),
      .inst_valid_o (inst_valid_o)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] rom_fn(input logic [31:0] a);
      return a ^ 32'hDEAD_0000;
   endfunction

   always @(posedge clk)
      if (rom_req_o)
         rom_data_i <= rom_fn(rom_addr_o);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance to the next falling edge, apply inputs, let combinational outputs settle.
   task automatic step(input logic r, input logic h, input logic j, input logic [31:0] ja);
      @(negedge clk);
      rst = r;
      hold_flag_i = h;
      jump_flag_i = j;
      jump_addr_i = ja;
      #1;
   endtask

   task automatic expect_out(input string tag, input logic e_req, input logic [31:0] e_raddr,
                             input logic e_vld, input logic [31:0] e_iaddr);
      chk({tag, ".req"}, {31'd0, rom_req_o}, {31'd0, e_req});
      if (e_req)
         chk({tag, ".rom_addr"}, rom_addr_o, e_raddr);
      chk({tag, ".valid"}, {31'd0, inst_valid_o}, {31'd0, e_vld});
      if (e_vld) begin
         chk({tag, ".inst_addr"}, inst_addr_o, e_iaddr);
         chk({tag, ".inst"}, inst_o, rom_fn(e_iaddr));
      end else begin
         chk({tag, ".inst_nop"}, inst_o, NOP);
      end
   endtask

   initial begin
      // Reset held
      step(0, 0, 0, 32'd0);
      step(0, 0, 0, 32'd0);
      expect_out("rst", 0, 32'd0, 0, 32'd0);
      chk("rst.inst_addr", inst_addr_o, 32'd0);

      // Streaming from reset release
      step(1, 0, 0, 32'd0);  expect_out("s0", 1, 32'h00, 0, 32'd0);
      step(1, 0, 0, 32'd0);  expect_out("s1", 1, 32'h04, 0, 32'd0);
      step(1, 0, 0, 32'd0);  expect_out("s2", 1, 32'h08, 1, 32'h00);
      step(1, 0, 0, 32'd0);  expect_out("s3", 1, 32'h0C, 1, 32'h04);
      step(1, 0, 0, 32'd0);  expect_out("s4", 1, 32'h10, 1, 32'h08);
      step(1, 0, 0, 32'd0);  expect_out("s5", 1, 32'h14, 1, 32'h0C);

      // Hold for three cycles with 0x10 at the head
      step(1, 1, 0, 32'd0);  expect_out("h0", 0, 32'h18, 1, 32'h10);
      step(1, 1, 0, 32'd0);  expect_out("h1", 0, 32'h18, 1, 32'h10);
      step(1, 1, 0, 32'd0);  expect_out("h2", 0, 32'h18, 1, 32'h10);
      step(1, 0, 0, 32'd0);  expect_out("h3", 1, 32'h18, 1, 32'h10);
      step(1, 0, 0, 32'd0);  expect_out("h4", 1, 32'h1C, 1, 32'h14);
      step(1, 0, 0, 32'd0);  expect_out("h5", 1, 32'h20, 1, 32'h18);

      // Fill the queue, then jump to 0x100 with two entries queued
      step(1, 1, 0, 32'd0);    expect_out("j0", 0, 32'h20, 1, 32'h1C);
      step(1, 0, 1, 32'h100);  expect_out("j1", 1, 32'h100, 0, 32'd0);
      step(1, 0, 0, 32'd0);    expect_out("j2", 1, 32'h104, 0, 32'd0);
      step(1, 0, 0, 32'd0);    expect_out("j3", 1, 32'h108, 1, 32'h100);
      step(1, 0, 0, 32'd0);    expect_out("j4", 1, 32'h10C, 1, 32'h104);

      // Jump and hold together: jump wins, target waits at the head
      step(1, 1, 1, 32'h100);  expect_out("jh0", 1, 32'h100, 0, 32'd0);
      step(1, 1, 0, 32'd0);    expect_out("jh1", 1, 32'h104, 0, 32'd0);
      step(1, 1, 0, 32'd0);    expect_out("jh2", 0, 32'h108, 1, 32'h100);
      step(1, 1, 0, 32'd0);    expect_out("jh3", 0, 32'h108, 1, 32'h100);
      step(1, 0, 0, 32'd0);    expect_out("jh4", 1, 32'h108, 1, 32'h100);
      step(1, 0, 0, 32'd0);    expect_out("jh5", 1, 32'h10C, 1, 32'h104);

      // Unaligned jump target
      step(1, 0, 1, 32'h203);  expect_out("ua0", 1, 32'h200, 0, 32'd0);
      step(1, 0, 0, 32'd0);    expect_out("ua1", 1, 32'h204, 0, 32'd0);
      step(1, 0, 0, 32'd0);    expect_out("ua2", 1, 32'h208, 1, 32'h200);
      step(1, 0, 0, 32'd0);    expect_out("ua3", 1, 32'h20C, 1, 32'h204);

      // Reset pulse with a full queue
      step(1, 1, 0, 32'd0);    expect_out("r0", 0, 32'h20C, 1, 32'h208);
      step(1, 1, 0, 32'd0);    expect_out("r1", 0, 32'h20C, 1, 32'h208);
      step(0, 0, 0, 32'd0);    expect_out("r2", 0, 32'd0, 0, 32'd0);
      chk("r2.inst_addr", inst_addr_o, 32'd0);
      step(1, 0, 0, 32'd0);    expect_out("r3", 1, 32'h00, 0, 32'd0);
      chk("r3.inst_addr", inst_addr_o, 32'd0);
      step(1, 0, 0, 32'd0);    expect_out("r4", 1, 32'h04, 0, 32'd0);
      step(1, 0, 0, 32'd0);    expect_out("r5", 1, 32'h08, 1, 32'h00);

      // PC wrap at the top of the address space
      step(1, 0, 1, 32'hFFFF_FFFF);  expect_out("w0", 1, 32'hFFFF_FFFC, 0, 32'd0);
      step(1, 0, 0, 32'd0);          expect_out("w1", 1, 32'h0000_0000, 0, 32'd0);
      step(1, 0, 0, 32'd0);          expect_out("w2", 1, 32'h0000_0004, 1, 32'hFFFF_FFFC);
      step(1, 0, 0, 32'd0);          expect_out("w3", 1, 32'h0000_0008, 1, 32'h0000_0000);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
